fpu_issue_sequencer: RTL and testbench

//  Sits between the CPU ESC-decode path and FPU8087_Direct. Buffers FPU instructions
//  (opcode, modrm, 80-bit operand) in a FIFO and issues them one at a time.

---
 rtl/fpu_issue_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_fpu_issue_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_sequencer.sv
// FPU instruction issue sequencer: buffers ESC/FWAIT instructions from the CPU
// decode path, issues them one at a time to the FPU, returns store results and
// FWAIT barrier acknowledgements, and flushes the queue on FPU error or timeout.
module fpu_issue_sequencer #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [7:0]             req_opcode,
    input  logic [7:0]             req_modrm,
    input  logic [79:0]            req_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [79:0]            rsp_data,
    output logic                   rsp_error,
    output logic [7:0]             fpu_opcode,
    output logic [7:0]             fpu_modrm,
    output logic [79:0]            fpu_data_in,
    output logic                   fpu_execute,
    input  logic                   fpu_ready,
    input  logic                   fpu_error,
    input  logic [79:0]            fpu_data_out,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic                   err_sticky,
    output logic                   timeout,
    input  logic                   err_clear
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PtrW:0]   FullCount  = (PtrW + 1)'(DEPTH);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StResp,
        StBarrier,
        StFlush
    } state_e;

    logic [7:0]  op_mem    [DEPTH];
    logic [7:0]  md_mem    [DEPTH];
    logic [79:0] dat_mem   [DEPTH];
    logic        store_mem [DEPTH];
    logic        wait_mem  [DEPTH];

    state_e          state_q, state_d;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q, count_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [79:0]     rsp_data_q, rsp_data_d;
    logic            rsp_error_q, rsp_error_d;
    logic [7:0]      fpu_op_q, fpu_md_q;
    logic [79:0]     fpu_dat_q;
    logic            cur_store_q;
    logic            err_sticky_q, timeout_q, timeout_d;
    logic            push, pop, clear, load_fpu, err_set;
    logic            enq_store;

    assign push      = req_valid && req_ready;
    assign cnt_inc   = cnt_q + 1'b1;
    assign enq_store = (req_opcode == 8'hDB && req_modrm[5:3] == 3'd7) ||
                       (req_opcode == 8'hDD && req_modrm[7:6] != 2'd3 &&
                        (req_modrm[5:3] == 3'd2 || req_modrm[5:3] == 3'd3));

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q]    <= req_opcode;
            md_mem[wr_ptr_q]    <= req_modrm;
            dat_mem[wr_ptr_q]   <= req_data;
            store_mem[wr_ptr_q] <= enq_store;
            wait_mem[wr_ptr_q]  <= (req_opcode == 8'h9B);
        end
    end

    // Next-state, pop/issue decisions, response capture and fault handling
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        timeout_d   = 1'b0;
        pop         = 1'b0;
        clear       = 1'b0;
        load_fpu    = 1'b0;
        err_set     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (wait_mem[rd_ptr_q]) begin
                        state_d = StBarrier;
                    end else begin
                        load_fpu = 1'b1;
                        state_d  = StIssue;
                    end
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (fpu_ready) begin
                    if (fpu_error) begin
                        err_set = 1'b1;
                        clear   = 1'b1;
                        state_d = StFlush;
                    end else if (cur_store_q) begin
                        rsp_data_d  = fpu_data_out;
                        rsp_error_d = 1'b0;
                        state_d     = StResp;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    // Expire after exactly TIMEOUT_CYCLES cycles spent in WAIT
                    if (cnt_inc == TimeoutVal) begin
                        timeout_d = 1'b1;
                        err_set   = 1'b1;
                        clear     = 1'b1;
                        state_d   = StFlush;
                    end
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            StBarrier: begin
                rsp_data_d  = '0;
                rsp_error_d = err_sticky_q;
                state_d     = StResp;
            end
            StFlush: begin
                clear = 1'b1;
                if (cur_store_q) begin
                    rsp_data_d  = fpu_data_out;
                    rsp_error_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Queue occupancy: a flush overrides any push or pop in the same cycle
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cnt_q        <= '0;
            rsp_data_q   <= '0;
            rsp_error_q  <= 1'b0;
            fpu_op_q     <= '0;
            fpu_md_q     <= '0;
            fpu_dat_q    <= '0;
            cur_store_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            timeout_q   <= timeout_d;
            if (clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (load_fpu) begin
                fpu_op_q    <= op_mem[rd_ptr_q];
                fpu_md_q    <= md_mem[rd_ptr_q];
                fpu_dat_q   <= dat_mem[rd_ptr_q];
                cur_store_q <= store_mem[rd_ptr_q];
            end
            if (err_set) begin
                err_sticky_q <= 1'b1;
            end else if (err_clear) begin
                err_sticky_q <= 1'b0;
            end
        end
    end

    assign req_ready   = (count_q != FullCount) && (state_q != StFlush);
    assign rsp_valid   = (state_q == StResp);
    assign rsp_data    = rsp_data_q;
    assign rsp_error   = rsp_error_q;
    assign fpu_opcode  = fpu_op_q;
    assign fpu_modrm   = fpu_md_q;
    assign fpu_data_in = fpu_dat_q;
    assign fpu_execute = (state_q == StIssue);
    assign busy        = (count_q != '0) || (state_q != StIdle);
    assign queue_count = count_q;
    assign err_sticky  = err_sticky_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Self-checking bench for fpu_issue_sequencer: directed scenarios plus a random
// instruction stream checked against a queue-based reference model and a toy FPU.
module tb_fpu_issue_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 40;
    localparam logic [79:0] ONE   = 80'h3FFF8000000000000000;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  md;
        logic [79:0] d;
    } ins_t;

    typedef struct {
        logic [79:0] d;
        logic        err;
        int          execs;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, rsp_valid, rsp_ready, rsp_error;
    logic [7:0]  req_opcode, req_modrm, fpu_opcode, fpu_modrm;
    logic [79:0] req_data, rsp_data, fpu_data_in, fpu_data_out;
    logic        fpu_execute, fpu_ready, fpu_error, busy, err_sticky, timeout, err_clear;
    logic [$clog2(DEPTH):0] queue_count;

    ins_t exp_exec[$];
    rsp_t exp_rsp[$];
    int   checks = 0, passes = 0, fails = 0;
    int   cyc = 0, exec_seen = 0, last_exec = -100, model_nonwait = 0, lat_max = 0;
    int   base = 0, pend_left = 0;
    bit   model_on = 0, manual = 1, rnd_rsp = 0, pend = 0, hold_prev = 0;
    logic man_ready = 0, man_error = 0, man_rsp_ready = 1, rnd_ready = 1, auto_ready = 0;
    logic prev_err = 0;
    logic [79:0] man_data = 0, auto_data = 0, fpu_st = 0, model_st = 0, prev_data = 0;
    logic [15:0] tbl [10] = '{16'hD9E8, 16'hD9E0, 16'hD9E1, 16'hDB28, 16'hDB38,
                              16'hDD10, 16'hDD18, 16'hDDD8, 16'h9B00, 16'hDD5A};

    assign fpu_ready    = manual ? man_ready : auto_ready;
    assign fpu_error    = manual ? man_error : 1'b0;
    assign fpu_data_out = manual ? man_data : auto_data;
    assign rsp_ready    = rnd_rsp ? rnd_ready : man_rsp_ready;

    fpu_issue_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_modrm(req_modrm), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .fpu_opcode(fpu_opcode), .fpu_modrm(fpu_modrm),
        .fpu_data_in(fpu_data_in), .fpu_execute(fpu_execute), .fpu_ready(fpu_ready),
        .fpu_error(fpu_error), .fpu_data_out(fpu_data_out), .busy(busy),
        .queue_count(queue_count), .err_sticky(err_sticky), .timeout(timeout),
        .err_clear(err_clear)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Toy single-register FPU: FLD1, FCHS, FABS, FLD m80; everything else keeps ST
    function automatic logic [79:0] fpu_eval(input logic [7:0] op, input logic [7:0] md,
                                             input logic [79:0] d, input logic [79:0] st);
        logic [15:0] k;
        k = {op, md};
        case (k)
            16'hD9E8: return ONE;
            16'hD9E0: return {~st[79], st[78:0]};
            16'hD9E1: return {1'b0, st[78:0]};
            16'hDB28: return d;
            default:  return st;
        endcase
    endfunction

    function automatic bit is_store_ref(input logic [7:0] op, input logic [7:0] md);
        return (op == 8'hDB && md[5:3] == 3'd7) ||
               (op == 8'hDD && md[7:6] != 2'd3 && md[5:4] == 2'b01);
    endfunction

    // Expected behaviour of one accepted instruction
    task automatic model_push(input logic [7:0] op, input logic [7:0] md, input logic [79:0] d);
        rsp_t r;
        ins_t e;
        if (op == 8'h9B) begin
            r.d = '0; r.err = 1'b0; r.execs = model_nonwait;
            exp_rsp.push_back(r);
        end else begin
            e.op = op; e.md = md; e.d = d;
            exp_exec.push_back(e);
            model_nonwait++;
            model_st = fpu_eval(op, md, d, model_st);
            if (is_store_ref(op, md)) begin
                r.d = model_st; r.err = 1'b0; r.execs = -1;
                exp_rsp.push_back(r);
            end
        end
    endtask

    task automatic model_enable();
        model_st      = fpu_st;
        model_nonwait = exec_seen;
        model_on      = 1;
    endtask

    // Called and returns at a negedge; holds req_valid until accepted
    task automatic push(input logic [7:0] op, input logic [7:0] md, input logic [79:0] d);
        int n;
        bit acc;
        n = 0;
        req_valid = 1'b1; req_opcode = op; req_modrm = md; req_data = d;
        do begin
            acc = req_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 300);
        req_valid = 1'b0;
        if (!acc) chk("push_timeout", 96'(1), 96'(0));
        else if (model_on) model_push(op, md, d);
    endtask

    task automatic wait_exec(input string tag);
        int n;
        n = 0;
        while (fpu_execute !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 96'(fpu_execute), 96'(1));
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 96'(rsp_valid), 96'(1));
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_exec.size() != 0 || exp_rsp.size() != 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 96'({busy, exp_exec.size() != 0, exp_rsp.size() != 0}), 96'(0));
    endtask

    task automatic wait_timeout(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (timeout !== 1'b1 && n < 3 * TMO);
        chk(tag, 96'(n), 96'(TMO + 1));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctl"}, 96'({req_ready, rsp_valid, rsp_error, fpu_execute, busy,
                                err_sticky, timeout}), 96'(7'b1000000));
        chk({tag, "_cnt"}, 96'(queue_count), 96'(0));
        chk({tag, "_fpu"}, {fpu_opcode, fpu_modrm, fpu_data_in}, 96'(0));
        chk({tag, "_rsp"}, 96'(rsp_data), 96'(0));
    endtask

    // Automatic FPU stand-in: ready after a random latency following each execute
    always @(negedge clk) begin
        if (!reset || manual) begin
            pend = 0;
            auto_ready = 1'b0;
        end else begin
            auto_ready = 1'b0;
            if (pend) begin
                if (pend_left == 0) begin
                    auto_ready = 1'b1;
                    auto_data  = fpu_st;
                    pend       = 0;
                end else begin
                    pend_left--;
                end
            end
            if (fpu_execute) begin
                fpu_st    = fpu_eval(fpu_opcode, fpu_modrm, fpu_data_in, fpu_st);
                pend      = 1;
                pend_left = int'($urandom_range(0, lat_max));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    // Execute monitor: issue order, operand contents and issue spacing
    always @(negedge clk) begin
        ins_t e;
        #1;
        if (!reset) begin
            last_exec = -100;
        end else if (fpu_execute) begin
            exec_seen++;
            chk("exec_gap", 96'(cyc - last_exec >= 3), 96'(1));
            last_exec = cyc;
            if (model_on) begin
                if (exp_exec.size() == 0) begin
                    chk("exec_unexpected", 96'(1), 96'(0));
                end else begin
                    e = exp_exec.pop_front();
                    chk("exec_ins", {fpu_opcode, fpu_modrm, fpu_data_in}, {e.op, e.md, e.d});
                end
            end
        end
    end

    // Response monitor: hold-stability under backpressure and expected payloads
    always @(negedge clk) begin
        rsp_t r;
        #1;
        if (!reset) begin
            hold_prev = 0;
        end else begin
            if (hold_prev && rsp_valid)
                chk("rsp_stable", {15'b0, rsp_error, rsp_data}, {15'b0, prev_err, prev_data});
            hold_prev = rsp_valid && !rsp_ready;
            prev_data = rsp_data;
            prev_err  = rsp_error;
            if (rsp_valid && rsp_ready && model_on) begin
                if (exp_rsp.size() == 0) begin
                    chk("rsp_unexpected", 96'(1), 96'(0));
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_payload", {15'b0, rsp_error, rsp_data}, {15'b0, r.err, r.d});
                    if (r.execs >= 0) chk("barrier_order", 96'(exec_seen), 96'(r.execs));
                end
            end
        end
    end

    initial begin
        logic [79:0] d;
        logic [15:0] t;
        reset = 1'b0; req_valid = 1'b0; req_opcode = '0; req_modrm = '0; req_data = '0;
        err_clear = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("rst_init");
        reset = 1'b1;
        @(negedge clk);

        // 1: FLD1 then FSTP m80 back-to-back
        manual = 0; lat_max = 0;
        model_enable();
        push(8'hD9, 8'hE8, 80'h0);
        push(8'hDB, 8'h38, 80'h55);
        wait_idle("t1_idle", 100);
        model_on = 0;

        // 2: fill the queue behind a stalled op, then push+pop in the same cycle
        manual = 1; base = exec_seen;
        repeat (DEPTH + 1) push(8'hD9, 8'hE0, 80'h0);
        chk("t2_full_cnt", 96'(queue_count), 96'(DEPTH));
        chk("t2_full_rdy", 96'(req_ready), 96'(0));
        man_ready = 1'b1; @(negedge clk); man_ready = 1'b0;
        chk("t2_idle_full_rdy", 96'(req_ready), 96'(0));
        @(negedge clk);
        chk("t2_pop_cnt", 96'({fpu_execute, req_ready, 3'(queue_count)}), 96'({2'b11, 3'd3}));
        @(negedge clk);
        man_ready = 1'b1; @(negedge clk); man_ready = 1'b0;
        req_valid = 1'b1; req_opcode = 8'hD9; req_modrm = 8'hE0; req_data = '0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("t2_pushpop_cnt", 96'({fpu_execute, 3'(queue_count)}), 96'({1'b1, 3'd3}));
        begin
            int n;
            n = 0;
            while (busy && n < 200) begin
                if (fpu_execute) begin
                    @(negedge clk); man_ready = 1'b1;
                    @(negedge clk); man_ready = 1'b0;
                end else begin
                    @(negedge clk);
                end
                n++;
            end
        end
        chk("t2_drained", 96'({busy, 8'(exec_seen - base)}), 96'({1'b0, 8'd6}));

        // 3: FLD m80, FABS, FWAIT barrier, FSTP
        manual = 0; lat_max = 2;
        model_enable();
        push(8'hDB, 8'h28, 80'hC000A000000000000000);
        push(8'hD9, 8'hE1, 80'h0);
        push(8'h9B, 8'h00, 80'h0);
        push(8'hDB, 8'h38, 80'h0);
        wait_idle("t3_idle", 200);
        model_on = 0;
        chk("t3_st", 96'(fpu_st), 96'(80'h4000A000000000000000));

        // 4: error on op 1 of 3, with err_clear in the same cycle
        manual = 1; base = exec_seen;
        push(8'hD9, 8'hE0, 80'h0);
        push(8'hD9, 8'hE1, 80'h0);
        push(8'hD9, 8'hE8, 80'h0);
        man_ready = 1'b1; man_error = 1'b1; err_clear = 1'b1;
        @(negedge clk);
        man_ready = 1'b0; man_error = 1'b0; err_clear = 1'b0;
        chk("t4_flush", 96'({err_sticky, req_ready, 3'(queue_count)}), 96'({2'b10, 3'd0}));
        repeat (4) @(negedge clk);
        chk("t4_quiet", 96'({busy, rsp_valid, 8'(exec_seen - base)}), 96'({2'b00, 8'd1}));
        push(8'h9B, 8'h00, 80'h0);
        wait_rsp("t4_barrier_valid");
        chk("t4_barrier", {15'b0, rsp_error, rsp_data}, {15'b0, 1'b1, 80'h0});
        err_clear = 1'b1; @(negedge clk); err_clear = 1'b0;
        chk("t4_clear", 96'(err_sticky), 96'(0));

        // 5a: timeout on a non-store with another op queued behind it
        man_data = 80'h1234_5678_9ABC_DEF0_1357;
        push(8'hD9, 8'hE0, 80'h0);
        push(8'hD9, 8'hE1, 80'h0);
        wait_exec("t5_exec");
        wait_timeout("t5_tmo_cycles");
        chk("t5_flush", 96'({err_sticky, req_ready, 3'(queue_count)}), 96'({2'b10, 3'd0}));
        @(negedge clk);
        chk("t5_after", 96'({timeout, busy, rsp_valid}), 96'(0));
        // 5b: timeout on a store returns an error response carrying fpu_data_out
        push(8'hDB, 8'h38, 80'h0);
        wait_exec("t5b_exec");
        wait_timeout("t5b_tmo_cycles");
        @(negedge clk);
        chk("t5b_rsp", {15'b0, rsp_valid, rsp_error, rsp_data}, {14'b0, 2'b11, man_data});
        @(negedge clk);
        chk("t5b_idle", 96'(busy), 96'(0));
        err_clear = 1'b1; @(negedge clk); err_clear = 1'b0;

        // 6: reset during WAIT, then during RESP under backpressure
        push(8'hD9, 8'hE0, 80'h0);
        wait_exec("t6_exec");
        @(negedge clk);
        reset = 1'b0; @(negedge clk);
        check_reset("t6_rst_wait");
        reset = 1'b1;
        man_rsp_ready = 1'b0;
        push(8'hDB, 8'h38, 80'h0);
        wait_exec("t6b_exec");
        @(negedge clk);
        man_ready = 1'b1; @(negedge clk); man_ready = 1'b0;
        chk("t6_resp", {15'b0, rsp_valid, rsp_data}, {15'b0, 1'b1, man_data});
        reset = 1'b0; @(negedge clk);
        check_reset("t6_rst_resp");
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_no_stale", 96'({rsp_valid, busy}), 96'(0));
        man_rsp_ready = 1'b1;

        // Random stream with random FPU latency and response backpressure
        manual = 0; rnd_rsp = 1; lat_max = 3;
        model_enable();
        for (int i = 0; i < 60; i++) begin
            t = tbl[$urandom_range(0, 9)];
            d = {16'($urandom), $urandom, $urandom};
            push(t[15:8], t[7:0], d);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        wait_idle("rand_idle", 3000);
        model_on = 0; rnd_rsp = 0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
